// File: rtl/y86_decode_pipe.sv
// y86_decode_pipe
// Registered Y86 decode stage between fetch and execute.
// Takes one raw instruction window per cycle over valid/ready. It splits the
// window into icode/ifun, register IDs, constant and fall-through PC. It also
// computes the instruction length and flags illegal encodings. A main output
// register plus one skid register let fetch and execute stall independently.
// Once HALT or an illegal instruction is accepted, intake stops until a flush.
//
// Parameters: WORD_BYTES (4 or 8), PC_W (PC width in bits).
// Ports:
//   clk, rst (sync, active-high), flush (sync pipeline flush)
//   in_valid/in_ready, in_pc, in_inst  : fetch side, byte k at in_inst[8k+7:8k]
//   out_valid/out_ready                : execute side
//   out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP, out_len, out_err
module y86_decode_pipe #(
    parameter int WORD_BYTES = 4,
    parameter int PC_W       = 16,
    localparam int IW        = 8 * (2 + WORD_BYTES),
    localparam int W         = 8 * WORD_BYTES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [IW-1:0]   in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_icode,
    output logic [3:0]      out_ifun,
    output logic [3:0]      out_rA,
    output logic [3:0]      out_rB,
    output logic [W-1:0]    out_valC,
    output logic [PC_W-1:0] out_valP,
    output logic [3:0]      out_len,
    output logic            out_err
);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPL   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [3:0] R_NONE  = 4'hF;

    localparam logic [3:0] LEN_MEM = 4'(2 + WORD_BYTES);
    localparam logic [3:0] LEN_JMP = 4'(1 + WORD_BYTES);

    // One decoded entry, packed so main and skid registers move as a unit.
    localparam int EW = 16 + W + PC_W + 5;
    localparam logic [EW-1:0] RESET_E = {4'h0, 4'h0, R_NONE, R_NONE,
                                         {W{1'b0}}, {PC_W{1'b0}}, 4'h0, 1'b0};

    logic [3:0]      d_icode, d_ifun, d_ra, d_rb, d_len;
    logic [W-1:0]    d_valc;
    logic [PC_W-1:0] d_valp;
    logic            d_err;
    logic [EW-1:0]   dec_e, main_e, skid_e;
    logic            main_valid, skid_valid, halt_lock;
    logic            accept, main_free;

    always_comb begin
        d_icode = in_inst[7:4];
        d_ifun  = in_inst[3:0];
        d_err   = 1'b0;
        d_len   = 4'd1;
        d_ra    = R_NONE;
        d_rb    = R_NONE;
        d_valc  = '0;
        case (d_icode)
            I_HALT, I_NOP, I_RET: d_err = (d_ifun != 4'h0);
            I_CMOV, I_OPL: begin
                d_err = (d_icode == I_OPL) ? (d_ifun > 4'd3) : (d_ifun > 4'd6);
                d_len = 4'd2;
                d_ra  = in_inst[15:12];
                d_rb  = in_inst[11:8];
            end
            I_IRMOV, I_RMMOV, I_MRMOV: begin
                d_err  = (d_ifun != 4'h0);
                d_len  = LEN_MEM;
                d_ra   = (d_icode == I_IRMOV) ? R_NONE : in_inst[15:12];
                d_rb   = in_inst[11:8];
                d_valc = in_inst[16 +: W];
            end
            I_JXX, I_CALL: begin
                d_err  = (d_icode == I_JXX) ? (d_ifun > 4'd6) : (d_ifun != 4'h0);
                d_len  = LEN_JMP;
                d_valc = in_inst[8 +: W];
            end
            I_PUSH, I_POP: begin
                d_err = (d_ifun != 4'h0);
                d_len = 4'd2;
                d_ra  = in_inst[15:12];
            end
            default: d_err = 1'b1;
        endcase
        // Illegal entries still flow downstream, but as a harmless 1-byte shell.
        if (d_err) begin
            d_len  = 4'd1;
            d_ra   = R_NONE;
            d_rb   = R_NONE;
            d_valc = '0;
        end
        d_valp = in_pc + PC_W'(d_len);
        dec_e  = {d_icode, d_ifun, d_ra, d_rb, d_valc, d_valp, d_len, d_err};
    end

    assign in_ready  = !skid_valid && !halt_lock;
    assign accept    = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            halt_lock  <= 1'b0;
            main_e     <= RESET_E;
            skid_e     <= RESET_E;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            halt_lock  <= 1'b0;
        end else begin
            if (main_free) begin
                // accept is impossible while skid is full, so no conflict here.
                if (skid_valid) begin
                    main_e     <= skid_e;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_e     <= dec_e;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_e     <= dec_e;
                skid_valid <= 1'b1;
            end
            if (accept && (d_err || d_icode == I_HALT))
                halt_lock <= 1'b1;
        end
    end

    assign out_valid = main_valid;
    assign {out_icode, out_ifun, out_rA, out_rB,
            out_valC, out_valP, out_len, out_err} = main_e;

endmodule

// File: tb/tb_y86_decode_pipe.sv
module tb_y86_decode_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    // 32-bit word instance
    logic        v4 = 1'b0, rdy4, ov4, ordy4 = 1'b1, err4;
    logic [15:0] pc4 = '0, valp4;
    logic [47:0] inst4 = '0;
    logic [3:0]  icode4, ifun4, ra4, rb4, len4;
    logic [31:0] valc4;
    logic [68:0] got4;

    // 64-bit word instance
    logic        v8 = 1'b0, rdy8, ov8, ordy8 = 1'b1, err8;
    logic [15:0] pc8 = '0, valp8;
    logic [79:0] inst8 = '0;
    logic [3:0]  icode8, ifun8, ra8, rb8, len8;
    logic [63:0] valc8;
    logic [100:0] got8;

    int total = 0;
    int bad = 0;

    localparam logic [68:0]  RST4 = {4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 16'h0, 4'h0, 1'b0};
    localparam logic [100:0] RST8 = {4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 16'h0, 4'h0, 1'b0};

    y86_decode_pipe #(.WORD_BYTES(4), .PC_W(16)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(v4), .in_ready(rdy4), .in_pc(pc4), .in_inst(inst4),
        .out_valid(ov4), .out_ready(ordy4),
        .out_icode(icode4), .out_ifun(ifun4), .out_rA(ra4), .out_rB(rb4),
        .out_valC(valc4), .out_valP(valp4), .out_len(len4), .out_err(err4)
    );

    y86_decode_pipe #(.WORD_BYTES(8), .PC_W(16)) dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(v8), .in_ready(rdy8), .in_pc(pc8), .in_inst(inst8),
        .out_valid(ov8), .out_ready(ordy8),
        .out_icode(icode8), .out_ifun(ifun8), .out_rA(ra8), .out_rB(rb8),
        .out_valC(valc8), .out_valP(valp8), .out_len(len8), .out_err(err8)
    );

    assign got4 = {icode4, ifun4, ra4, rb4, valc4, valp4, len4, err4};
    assign got8 = {icode8, ifun8, ra8, rb8, valc8, valp8, len8, err8};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL reset_ov4 got=%b exp=0", ov4); end
        total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL reset_rdy4 got=%b exp=1", rdy4); end
        total++; if (got4 !== RST4) begin bad++; $display("FAIL reset_fields4 got=%h exp=%h", got4, RST4); end
        total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL reset_ov8 got=%b exp=0", ov8); end
        total++; if (got8 !== RST8) begin bad++; $display("FAIL reset_fields8 got=%h exp=%h", got8, RST8); end
    endtask

    task automatic test_irmovl();
        logic [68:0] exp;
        exp = {4'h3, 4'h0, 4'hF, 4'h3, 32'h12345678, 16'h0016, 4'd6, 1'b0};
        ordy4 = 1'b1;
        pc4 = 16'h0010;
        inst4 = 48'h12345678F330;
        v4 = 1'b1;
        step();
        v4 = 1'b0;
        total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL irmovl_valid got=%b exp=1", ov4); end
        total++; if (got4 !== exp) begin bad++; $display("FAIL irmovl_fields got=%h exp=%h", got4, exp); end
        step();
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL irmovl_drain got=%b exp=0", ov4); end
    endtask

    task automatic test_jxx_wrap();
        logic [68:0] exp;
        exp = {4'h7, 4'h4, 4'hF, 4'hF, 32'h00000100, 16'h0003, 4'd5, 1'b0};
        pc4 = 16'hFFFE;
        inst4 = 48'h000000010074;
        v4 = 1'b1;
        step();
        v4 = 1'b0;
        total++; if (got4 !== exp) begin bad++; $display("FAIL jxx_wrap got=%h exp=%h", got4, exp); end
        step();
    endtask

    task automatic test_call64();
        logic [100:0] exp;
        exp = {4'h8, 4'h0, 4'hF, 4'hF, 64'h8877665544332211, 16'h0109, 4'd9, 1'b0};
        pc8 = 16'h0100;
        inst8 = 80'h00_88_77_66_55_44_33_22_11_80;
        v8 = 1'b1;
        step();
        v8 = 1'b0;
        total++; if (ov8 !== 1'b1) begin bad++; $display("FAIL call64_valid got=%b exp=1", ov8); end
        total++; if (got8 !== exp) begin bad++; $display("FAIL call64_fields got=%h exp=%h", got8, exp); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [47:0] ins [4];
        logic [15:0] pcs [4];
        logic [68:0] exps [4];
        ins[0] = 48'hDEADBEEF1240; pcs[0] = 16'h0030;
        exps[0] = {4'h4, 4'h0, 4'h1, 4'h2, 32'hDEADBEEF, 16'h0036, 4'd6, 1'b0};
        ins[1] = 48'h000000043450; pcs[1] = 16'h0036;
        exps[1] = {4'h5, 4'h0, 4'h3, 4'h4, 32'h00000004, 16'h003C, 4'd6, 1'b0};
        ins[2] = 48'h000000000090; pcs[2] = 16'h003C;
        exps[2] = {4'h9, 4'h0, 4'hF, 4'hF, 32'h0, 16'h003D, 4'd1, 1'b0};
        ins[3] = 48'h000000006725; pcs[3] = 16'h003D;
        exps[3] = {4'h2, 4'h5, 4'h6, 4'h7, 32'h0, 16'h003F, 4'd2, 1'b0};
        ordy4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst4 = ins[i];
            pc4 = pcs[i];
            v4 = 1'b1;
            step();
            total++; if (got4 !== exps[i] || ov4 !== 1'b1)
                begin bad++; $display("FAIL b2b_%0d got=%h/%b exp=%h/1", i, got4, ov4, exps[i]); end
            total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, rdy4); end
        end
        v4 = 1'b0;
        step();
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", ov4); end
    endtask

    task automatic test_backpressure();
        logic [68:0] e_nop, e_opl, e_push;
        e_nop  = {4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 16'h0021, 4'd1, 1'b0};
        e_opl  = {4'h6, 4'h0, 4'h1, 4'h2, 32'h0, 16'h0023, 4'd2, 1'b0};
        e_push = {4'hA, 4'h0, 4'h3, 4'hF, 32'h0, 16'h0025, 4'd2, 1'b0};
        ordy4 = 1'b0;
        pc4 = 16'h0020; inst4 = 48'h000000000010; v4 = 1'b1;
        step();
        total++; if (got4 !== e_nop || ov4 !== 1'b1) begin bad++; $display("FAIL bp_first got=%h exp=%h", got4, e_nop); end
        total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", rdy4); end
        pc4 = 16'h0021; inst4 = 48'h000000001260;
        step();
        total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%b exp=0", rdy4); end
        total++; if (got4 !== e_nop) begin bad++; $display("FAIL bp_hold1 got=%h exp=%h", got4, e_nop); end
        pc4 = 16'h0023; inst4 = 48'h000000003FA0;
        step();
        total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL bp_ready3 got=%b exp=0", rdy4); end
        total++; if (got4 !== e_nop || ov4 !== 1'b1) begin bad++; $display("FAIL bp_hold2 got=%h exp=%h", got4, e_nop); end
        ordy4 = 1'b1;
        step();
        total++; if (got4 !== e_opl || ov4 !== 1'b1) begin bad++; $display("FAIL bp_second got=%h exp=%h", got4, e_opl); end
        total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL bp_ready4 got=%b exp=1", rdy4); end
        step();
        v4 = 1'b0;
        total++; if (got4 !== e_push || ov4 !== 1'b1) begin bad++; $display("FAIL bp_third got=%h exp=%h", got4, e_push); end
        step();
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", ov4); end
    endtask

    task automatic test_illegal();
        logic [7:0]  ops [5];
        logic [68:0] exp;
        ops[0] = 8'h65; ops[1] = 8'hC0; ops[2] = 8'h77; ops[3] = 8'h27; ops[4] = 8'h91;
        ordy4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc4 = 16'h0050;
            inst4 = {40'h00000000AB, 8'h12} << 8 | {40'h0, ops[i]};
            exp = {ops[i][7:4], ops[i][3:0], 4'hF, 4'hF, 32'h0, 16'h0051, 4'd1, 1'b1};
            v4 = 1'b1;
            step();
            total++; if (got4 !== exp || ov4 !== 1'b1)
                begin bad++; $display("FAIL illegal_%h got=%h exp=%h", ops[i], got4, exp); end
            total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL illegal_lock_%h got=%b exp=0", ops[i], rdy4); end
            if (i == 0) begin
                pc4 = 16'h0051; inst4 = 48'h000000000010;
                repeat (3) step();
                total++; if (rdy4 !== 1'b0 || ov4 !== 1'b0)
                    begin bad++; $display("FAIL illegal_stuck got=%b/%b exp=0/0", rdy4, ov4); end
            end
            v4 = 1'b0;
            flush = 1'b1;
            step();
            flush = 1'b0;
            total++; if (ov4 !== 1'b0 || rdy4 !== 1'b1)
                begin bad++; $display("FAIL illegal_flush got=%b/%b exp=0/1", ov4, rdy4); end
        end
    endtask

    task automatic test_halt_lock();
        logic [68:0] exp;
        int seen;
        exp = {4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 16'h0041, 4'd1, 1'b0};
        ordy4 = 1'b1;
        pc4 = 16'h0040; inst4 = 48'h000000000000; v4 = 1'b1;
        step();
        total++; if (got4 !== exp || ov4 !== 1'b1) begin bad++; $display("FAIL halt_out got=%h exp=%h", got4, exp); end
        pc4 = 16'h0041; inst4 = 48'h000000000010;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ov4 === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL halt_leak got=%0d exp=0", seen); end
        total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL halt_ready got=%b exp=0", rdy4); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (ov4 !== 1'b0 || rdy4 !== 1'b1)
            begin bad++; $display("FAIL halt_flush_discard got=%b/%b exp=0/1", ov4, rdy4); end
        step();
        v4 = 1'b0;
        total++; if (ov4 !== 1'b1 || icode4 !== 4'h1)
            begin bad++; $display("FAIL halt_resume got=%b/%h exp=1/1", ov4, icode4); end
        step();
    endtask

    task automatic test_reset_mid();
        ordy4 = 1'b0;
        pc4 = 16'h0060; inst4 = 48'h000000000010; v4 = 1'b1;
        step();
        step();
        v4 = 1'b0;
        total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL rstmid_full got=%b exp=0", rdy4); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (ov4 !== 1'b0 || rdy4 !== 1'b1 || got4 !== RST4)
            begin bad++; $display("FAIL rstmid_clear got=%b/%b/%h exp=0/1/%h", ov4, rdy4, got4, RST4); end
        ordy4 = 1'b1;
        step();
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL rstmid_ghost got=%b exp=0", ov4); end
    endtask

    initial begin
        test_reset();
        test_irmovl();
        test_jxx_wrap();
        test_call64();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_halt_lock();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/y86_decode_pipe.md
# y86_decode_pipe

Registered, parametrised Y86 decode stage that sits between fetch and execute. Accepts one raw instruction window per cycle over a valid/ready handshake and splits it into icode, ifun, register IDs, constant and next PC. It also computes instruction length, flags illegal encodings and holds results in a two-entry skid buffer so fetch and execute can stall independently. A halt lock stops intake after HALT or an illegal instruction until a flush.

## Interface
- WORD_BYTES, 4: constant width in bytes; 4 (Y86-32) or 8 (Y86-64) only.
- PC_W, 16: PC width in bits.
- Derived: IW = 8*(2+WORD_BYTES) instruction window bits; W = 8*WORD_BYTES.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  decode can accept.
- in_pc  in  PC_W  address of byte 0.
- in_inst  in  IW  instruction window.
  - Byte k is at in_inst[8k+7:8k].
  - Byte 0 is {icode[7:4], ifun[3:0]}.
  - Byte 1 is {rA[7:4], rB[3:0]}.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  execute consumes the entry.
- out_icode, out_ifun, out_rA, out_rB  out  4 each  decoded fields.
- out_valC  out  W  constant.
- out_valP  out  PC_W  fall-through PC.
- out_len  out  4  instruction length in bytes.
- out_err  out  1  illegal instruction.

## Operation
- **Length**
  - HALT(0), NOP(1), RET(9): 1 byte.
  - CMOVXX(2), OPL(6), PUSHL(A), POPL(B): 2 bytes.
  - IRMOVL(3), RMMOVL(4), MRMOVL(5): 2+WORD_BYTES bytes.
  - JXX(7), CALL(8): 1+WORD_BYTES bytes.
  - Illegal encodings: 1 byte.
- **Register fields**
  - rA/rB come from byte 1 only for 2-byte and 2+WORD_BYTES-byte classes; otherwise both are 0xF.
  - IRMOVL forces rA=0xF.
  - PUSHL/POPL force rB=0xF.
- **Constant (out_valC), little-endian**
  - IRMOVL/RMMOVL/MRMOVL: bytes 2..WORD_BYTES+1.
  - JXX/CALL: bytes 1..WORD_BYTES.
  - All others: 0.
- **Next PC:** valP = in_pc + len, truncated to PC_W, so it wraps modulo 2^PC_W.
- **Illegal instruction (out_err=1)** when any of:
  - icode > 0xB;
  - OPL with ifun > 3;
  - CMOVXX/JXX with ifun > 6;
  - any other icode with ifun != 0.
  
  On an error the entry still passes through with its raw icode/ifun, len=1, rA=rB=0xF and valC=0.
- **Halt lock**
  - Set when an entry with icode=HALT (ifun 0) or err=1 is accepted.
  - While set, in_ready=0.
  - Cleared only by flush or rst.
- **Skid buffer:** holds a main output register plus one skid register.
  - in_ready = !skid_valid && !halt_lock.
  - Accept = in_valid && in_ready.
  - Accept while the main register is empty, or draining this cycle: the entry loads main.
  - Accept while main is held (out_valid && !out_ready): the entry loads skid.
  - When main drains and skid is full: skid moves into main and skid empties.
- **Flush**
  - Clears both valid bits and the halt lock.
  - Input offered in the flush cycle is discarded.
  - rst has priority over flush.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N.
- Throughput is 1 instruction/cycle while out_ready=1.
- out_* fields are held stable while out_valid && !out_ready.
- in_ready is combinational from internal state only. It does not depend on in_valid or out_ready.
- After reset, the first accept can occur in the cycle after rst deasserts.
- **Reset values:** out_valid=0, skid empty, halt lock clear, in_ready=1, icode=ifun=0, rA=rB=0xF, valC=0, valP=0, len=0, err=0.
- **Reset mid-operation:** all entries are dropped and no partial entry is ever presented.
- **Simultaneous events**
  - Accept plus drain with skid empty: main is replaced with no bubble.
  - Drain with skid full and in_ready low: skid moves to main and in_ready rises on the next cycle.
  - Flush plus out_ready: nothing is consumed after the edge.

## Test plan
- **Reset:** hold rst for 2 cycles → out_valid=0, in_ready=1, rA=rB=0xF, valP=0.
- **Decode, WORD_BYTES=4:**
  - IRMOVL bytes 30 F3 78 56 34 12 at pc=0x0010 → icode=3, rA=F, rB=3, valC=0x12345678, len=6, valP=0x0016, err=0.
  - JXX 74 00 01 00 00 at pc=0xFFFE → valC=0x100, len=5, valP=0x0003 (wrap).
- **Decode, WORD_BYTES=8:** CALL at pc=0x0100 → len=9, valP=0x0109, valC = bytes 1..8.
- **Back-pressure:**
  - Feed NOP, OPL, PUSHL back-to-back with out_ready=0 → first two accepted, in_ready=0 from the cycle after the second.
  - Raise out_ready → the three entries emerge in order with no duplicates or drops.
- **Illegal instruction:** bytes 65 .. (OPL ifun=5) → err=1, len=1, rA=rB=F; in_ready stays 0 until flush. Then pulse flush → out_valid=0, in_ready=1.
- **HALT lock:** HALT followed by a NOP offered continuously → only HALT emerges. A flush in the same cycle a NOP is offered → that NOP is discarded.
